ysyx_22050243_mem_arbiter: RTL and testbench
============================================

# ysyx_22050243_mem_arbiter

Shares one downstream memory port between the core's instruction-fetch requester and its load/store requester. Holds one transaction outstanding at a time and arbitrates round-robin with data-side preference on ties. Includes a response-timeout watchdog. Sits between the pipeline's IF/MEM stages and the memory/bus interface.

## Interface
- ADDR_WIDTH, 64, request address width (both requesters and downstream)
- DATA_WIDTH, 64, downstream and data-port data width
- INST_WIDTH, 32, instruction width returned to IF
- TIMEOUT, 255, max cycles to wait for a downstream response; 0 disables the watchdog
---
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  IF request, held high until `i_rsp_valid` is seen
- i_req_addr  in  ADDR_WIDTH  fetch address
- i_rsp_valid  out  1  one-cycle fetch response pulse
- i_rsp_inst  out  INST_WIDTH  fetched instruction
- i_rsp_err  out  1  fetch timed out
- d_req_valid  in  1  MEM request, held high until `d_rsp_valid` is seen
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_WIDTH  data address
- d_req_wdata  in  DATA_WIDTH  store data
- d_req_wmask  in  DATA_WIDTH/8  byte-enable mask
- d_rsp_valid  out  1  one-cycle data response pulse (load data or store ack)
- d_rsp_rdata  out  DATA_WIDTH  load data; 0 for stores
- d_rsp_err  out  1  data access timed out
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_req_we  out  1  downstream write enable
- mem_req_addr  out  ADDR_WIDTH  downstream address
- mem_req_wdata  out  DATA_WIDTH  downstream write data
- mem_req_wmask  out  DATA_WIDTH/8  downstream byte mask; all zeros for reads
- mem_rsp_valid  in  1  downstream response
- mem_rsp_rdata  in  DATA_WIDTH  downstream read data

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - If any request is valid, grant one, latch its fields into the request registers, record the owner (I or D), go to REQ.
  - An IF grant always issues a read: we = 0, wmask = 0.
- **Arbitration** (`last_d` flag, reset 0, set to the owner on each grant):
  - Only one request valid: that requester wins.
  - Both valid: D wins if `last_d` = 0; I wins if `last_d` = 1.
- **REQ:** `mem_req_valid` = 1 with the latched fields. Go to WAIT on the cycle `mem_req_valid & mem_req_ready`. The fields stay stable while waiting for ready.
- **WAIT:**
  - Counter starts at 0 on entry and increments each cycle.
  - On `mem_rsp_valid`: latch the data, set err = 0, go to RESP.
  - Else if TIMEOUT ≠ 0 and counter = TIMEOUT−1: set err = 1, data = 0, go to RESP.
- **RESP:**
  - Exactly one cycle. Only the owner's `*_rsp_valid` is 1.
  - `i_rsp_inst` = latched_data[63:32] if latched_addr[2] = 1, else latched_data[31:0].
  - `d_rsp_rdata` = latched data for loads, 0 for stores.
  - No grant is made in RESP, so a stale held request is never re-granted. Next state is IDLE.
- **Stray responses:** `mem_rsp_valid` outside WAIT is ignored, including a late response after a timeout.
- **Requester drops valid after grant:** the transaction still completes and the response pulse is still issued.
- **Reset mid-transaction:** return to IDLE immediately and drop the transaction; no response pulse is issued.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `mem_req_valid`, every `*_rsp_valid`, `*_rsp_err`, all data/address outputs; `last_d` = 0; counter 0.
- **Request sampled in IDLE at cycle N:** `mem_req_valid` = 1 at N+1.
- **Downstream ready at cycle R:** WAIT begins at R+1. `mem_rsp_valid` is sampled from R+1 on.
- **Response at cycle S:** `*_rsp_valid` = 1 at S+1. IDLE at S+2, and a new grant is possible at S+2.
- **Minimum turnaround:** zero-wait memory (ready at N+1, response at N+2) gives a request at N → response pulse at N+3; 4 cycles per transaction.
- **Timeout:** entering WAIT at W with no response gives `err` pulse at W+TIMEOUT.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- **Single fetch:** i_req_addr = 0x8000_0004, ready and response immediate, rdata = 0x1111_2222_3333_4444 → `i_rsp_valid` at N+3, `i_rsp_inst` = 0x1111_2222, err = 0; `mem_req_we` = 0, wmask = 0.
- **Store:** d_req_we = 1, addr = 0x8000_0100, wdata = 0xDEAD_BEEF, wmask = 0x0F → downstream fields match exactly; `d_rsp_valid` one cycle with rdata = 0.
- **Contention:** both requests held continuously, zero-wait memory → grants alternate D, I, D, I; each pulse lasts exactly 1 cycle; no requester gets two consecutive grants.
- **Backpressure:** `mem_req_ready` low for 5 cycles → `mem_req_valid` and all fields stable for 5 cycles, WAIT entered after the handshake; response returned correctly.
- **Timeout:** TIMEOUT = 8, no response → `d_rsp_err` = 1 and `d_rsp_rdata` = 0 exactly 8 cycles after WAIT entry; a later stray `mem_rsp_valid` produces no response pulse.
- **Reset during WAIT:** rst high for one cycle → next cycle all outputs 0, state IDLE, no response pulse; a new fetch then completes normally.

Source files
------------

// File: rtl/ysyx_22050243_mem_arbiter.sv
// ysyx_22050243_mem_arbiter
// Shares one downstream memory port between the instruction-fetch requester (I)
// and the load/store requester (D). One transaction is in flight at a time.
// Arbitration is round-robin on contention, starting with D after reset. A
// watchdog turns a missing downstream response into an error response.
// Every output is driven straight from a flop.

module ysyx_22050243_mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    // Instruction-fetch requester
    input  logic                    i_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_rsp_valid,
    output logic [INST_WIDTH-1:0]   i_rsp_inst,
    output logic                    i_rsp_err,

    // Load/store requester
    input  logic                    d_req_valid,
    input  logic                    d_req_we,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wmask,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_rdata,
    output logic                    d_rsp_err,

    // Downstream memory port
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
);

    // The watchdog counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    logic             r_owner_d;   // 1: current transaction belongs to D
    logic             r_last_d;    // 1: most recent grant went to D
    logic [CNT_W-1:0] r_cnt;       // cycles spent in WAIT

    logic                  w_any_req;
    logic                  w_grant_d;
    logic                  w_timeout;
    logic                  w_rsp_done;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic [INST_WIDTH-1:0] w_rsp_inst;

    // Grant to D when it is alone, or on contention when I was served last.
    assign w_any_req = i_req_valid | d_req_valid;
    assign w_grant_d = d_req_valid & (~i_req_valid | ~r_last_d);

    // A TIMEOUT of 0 disables the watchdog.
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_rsp_done = mem_rsp_valid | w_timeout;

    // A timed-out access returns zero data.
    assign w_rsp_data = mem_rsp_valid ? mem_rsp_rdata : '0;

    // Address bit 2 selects which half of the returned beat holds the instruction.
    assign w_rsp_inst = mem_req_addr[2] ? w_rsp_data[2*INST_WIDTH-1 -: INST_WIDTH]
                                        : w_rsp_data[INST_WIDTH-1:0];

    // Control FSM; it also owns every registered output.
    // NOTE: sequential state is assigned only with <= so each flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset clears every flop, including the latched request
            // fields, so nothing visible on the ports is ever undefined.
            r_state       <= S_IDLE;
            r_owner_d     <= 1'b0;
            r_last_d      <= 1'b0;
            r_cnt         <= '0;
            i_rsp_valid   <= 1'b0;
            i_rsp_inst    <= '0;
            i_rsp_err     <= 1'b0;
            d_rsp_valid   <= 1'b0;
            d_rsp_rdata   <= '0;
            d_rsp_err     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_d     <= w_grant_d;
                        r_last_d      <= w_grant_d;
                        mem_req_valid <= 1'b1;
                        r_state       <= S_REQ;
                        if (w_grant_d) begin
                            mem_req_we    <= d_req_we;
                            mem_req_addr  <= d_req_addr;
                            mem_req_wdata <= d_req_wdata;
                            // Loads never carry a byte mask downstream.
                            mem_req_wmask <= d_req_we ? d_req_wmask : '0;
                        end else begin
                            // Fetches are always plain reads.
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= i_req_addr;
                            mem_req_wdata <= '0;
                            mem_req_wmask <= '0;
                        end
                    end
                end

                S_REQ: begin
                    // Fields stay put until the downstream handshake.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_rsp_done) begin
                        r_state <= S_RESP;
                        if (r_owner_d) begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_rdata <= mem_req_we ? '0 : w_rsp_data;
                            d_rsp_err   <= ~mem_rsp_valid;
                        end else begin
                            i_rsp_valid <= 1'b1;
                            i_rsp_inst  <= w_rsp_inst;
                            i_rsp_err   <= ~mem_rsp_valid;
                        end
                    end
                end

                S_RESP: begin
                    // One-cycle pulse; no grant here so a still-held request
                    // that was just answered is not served twice.
                    i_rsp_valid <= 1'b0;
                    i_rsp_inst  <= '0;
                    i_rsp_err   <= 1'b0;
                    d_rsp_valid <= 1'b0;
                    d_rsp_rdata <= '0;
                    d_rsp_err   <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_mem_arbiter.sv
// tb_ysyx_22050243_mem_arbiter
// Directed bench for the memory arbiter. A cycle-stamped transaction model
// predicts when the downstream request is visible and when and what each
// response pulse carries; one negedge process compares every cycle. The
// directed tests add literal expectations that pin the model.

module tb_ysyx_22050243_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_rsp_valid;
    logic [IW-1:0] i_rsp_inst;
    logic          i_rsp_err;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic [7:0]    d_req_wmask;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_rdata;
    logic          d_rsp_err;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [7:0]    mem_req_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_rdata;

    ysyx_22050243_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INST_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_inst(i_rsp_inst), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;   // number of rising edges seen; "cycle k" follows edge k

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct {
        bit          own_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } txn_t;

    bit          armed     = 0;
    int          ph        = 0;    // 0 no transaction, 1 request phase, 2 waiting for response
    bit          m_last_d  = 0;
    int          t_free    = 0;    // first cycle whose inputs may be granted
    int          req_from  = 0;    // first cycle the downstream request is visible
    int          wait_from = 0;    // first cycle a response may be accepted
    int          pulse_cyc = -1;
    int          zero_cyc  = -1;
    txn_t        m_t;
    bit          p_own;
    bit          p_err;
    logic [63:0] p_data;

    // Advance the model with the inputs of the cycle that just ended.
    always @(posedge clk) begin : model
        int c;
        c   = cyc;
        cyc = cyc + 1;
        if (rst) begin
            armed     = 1;
            ph        = 0;
            pulse_cyc = -1;
            m_last_d  = 0;
            t_free    = c + 1;
            zero_cyc  = c + 1;
        end else if (armed) begin
            if (ph == 0) begin
                if (c >= t_free && (i_req_valid || d_req_valid)) begin
                    if (i_req_valid && d_req_valid) m_t.own_d = !m_last_d;
                    else                            m_t.own_d = d_req_valid;
                    m_last_d = m_t.own_d;
                    if (m_t.own_d) begin
                        m_t.we    = d_req_we;
                        m_t.addr  = d_req_addr;
                        m_t.wdata = d_req_wdata;
                        m_t.wmask = d_req_we ? d_req_wmask : 8'h00;
                    end else begin
                        m_t.we    = 0;
                        m_t.addr  = i_req_addr;
                        m_t.wdata = 64'h0;
                        m_t.wmask = 8'h00;
                    end
                    ph       = 1;
                    req_from = c + 1;
                end
            end else if (ph == 1) begin
                if (c >= req_from && mem_req_ready) begin
                    ph        = 2;
                    wait_from = c + 1;
                end
            end else begin
                if (c >= wait_from && mem_rsp_valid) begin
                    pulse_cyc = c + 1;
                    p_own = m_t.own_d; p_err = 0; p_data = mem_rsp_rdata;
                    ph = 0; t_free = c + 2;
                end else if (c - wait_from == TO - 1) begin
                    pulse_cyc = c + 1;
                    p_own = m_t.own_d; p_err = 1; p_data = 64'h0;
                    ph = 0; t_free = c + 2;
                end
            end
        end
    end

    // Compare every DUT output against the model, mid-cycle.
    always @(negedge clk) begin : compare
        bit          exp_mv;
        bit          pv;
        logic [31:0] exp_inst;
        if (armed) begin
            if (cyc == zero_cyc) begin
                check("rst_mem_req_valid", {63'h0, mem_req_valid}, 64'h0);
                check("rst_mem_req_we",    {63'h0, mem_req_we},    64'h0);
                check("rst_mem_req_addr",  mem_req_addr,           64'h0);
                check("rst_mem_req_wdata", mem_req_wdata,          64'h0);
                check("rst_mem_req_wmask", {56'h0, mem_req_wmask}, 64'h0);
                check("rst_i_rsp_valid",   {63'h0, i_rsp_valid},   64'h0);
                check("rst_i_rsp_inst",    {32'h0, i_rsp_inst},    64'h0);
                check("rst_i_rsp_err",     {63'h0, i_rsp_err},     64'h0);
                check("rst_d_rsp_valid",   {63'h0, d_rsp_valid},   64'h0);
                check("rst_d_rsp_rdata",   d_rsp_rdata,            64'h0);
                check("rst_d_rsp_err",     {63'h0, d_rsp_err},     64'h0);
            end else begin
                exp_mv = (ph == 1) && (cyc >= req_from);
                check("mem_req_valid", {63'h0, mem_req_valid}, {63'h0, exp_mv});
                if (exp_mv) begin
                    check("mem_req_we",    {63'h0, mem_req_we},    {63'h0, m_t.we});
                    check("mem_req_addr",  mem_req_addr,           m_t.addr);
                    check("mem_req_wmask", {56'h0, mem_req_wmask}, {56'h0, m_t.wmask});
                    if (m_t.we) check("mem_req_wdata", mem_req_wdata, m_t.wdata);
                end
                pv = (cyc == pulse_cyc);
                check("i_rsp_valid", {63'h0, i_rsp_valid}, {63'h0, pv && !p_own});
                check("d_rsp_valid", {63'h0, d_rsp_valid}, {63'h0, pv && p_own});
                check("i_rsp_err",   {63'h0, i_rsp_err},   {63'h0, pv && !p_own && p_err});
                check("d_rsp_err",   {63'h0, d_rsp_err},   {63'h0, pv && p_own && p_err});
                if (pv && !p_own) begin
                    exp_inst = m_t.addr[2] ? p_data[63:32] : p_data[31:0];
                    check("i_rsp_inst", {32'h0, i_rsp_inst}, {32'h0, exp_inst});
                end
                if (pv && p_own)
                    check("d_rsp_rdata", d_rsp_rdata, m_t.we ? 64'h0 : p_data);
            end
        end
    end

    // ---------------- downstream memory responder ----------------
    bit          resp_en      = 1;
    int          stall_cfg    = 0;
    int          stray_at_cyc = -100;
    logic [63:0] rd_val       = 64'h0;

    initial begin : responder
        int  wait_cnt;
        bit  hs_prev;
        wait_cnt      = 0;
        hs_prev       = 0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rsp_valid = (hs_prev && resp_en) || (cyc == stray_at_cyc);
            mem_rsp_rdata = rd_val;
            if (mem_req_valid) begin
                mem_req_ready = (wait_cnt >= stall_cfg);
                wait_cnt      = mem_req_ready ? 0 : wait_cnt + 1;
            end else begin
                mem_req_ready = 1'b0;
                wait_cnt      = 0;
            end
            hs_prev = mem_req_valid && mem_req_ready;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_pulse(input int budget, output int at, output bit own_d);
        at    = -1;
        own_d = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i_rsp_valid || d_rsp_valid) begin
                at    = cyc;
                own_d = d_rsp_valid;
                return;
            end
        end
        n_total++;
        n_bad++;
        $display("FAIL wait_pulse: no response within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    task automatic count_pulses(input int ncyc, output int np);
        np = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i_rsp_valid || d_rsp_valid) np++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        int at;
        int np;
        bit own;
        bit exp_own [4];
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        i_req_valid = 0; i_req_addr = '0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wmask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Store: downstream fields pass through, ack carries zero data.
        rd_val = 64'h5555_6666_7777_8888;
        d_req_valid = 1; d_req_we = 1; d_req_addr = 64'h8000_0100;
        d_req_wdata = 64'hDEAD_BEEF; d_req_wmask = 8'h0F;
        n = cyc;
        repeat (2) @(negedge clk);
        check("store_mem_valid", {63'h0, mem_req_valid}, 64'h1);
        check("store_mem_we",    {63'h0, mem_req_we},    64'h1);
        check("store_mem_addr",  mem_req_addr,           64'h8000_0100);
        check("store_mem_wdata", mem_req_wdata,          64'hDEAD_BEEF);
        check("store_mem_wmask", {56'h0, mem_req_wmask}, 64'h0F);
        wait_pulse(20, at, own);
        check("store_pulse_cyc", at, n + 3);
        check("store_owner",     {63'h0, own},         64'h1);
        check("store_rdata",     d_rsp_rdata,          64'h0);
        check("store_err",       {63'h0, d_rsp_err},   64'h0);
        step();
        d_req_valid = 0; d_req_we = 0;
        step();

        // Single fetch from the upper word of a beat.
        rd_val = 64'h1111_2222_3333_4444;
        i_req_valid = 1; i_req_addr = 64'h8000_0004;
        n = cyc;
        repeat (2) @(negedge clk);
        check("fetch_mem_we",    {63'h0, mem_req_we},    64'h0);
        check("fetch_mem_wmask", {56'h0, mem_req_wmask}, 64'h0);
        check("fetch_mem_addr",  mem_req_addr,           64'h8000_0004);
        wait_pulse(20, at, own);
        check("fetch_pulse_cyc", at, n + 3);
        check("fetch_owner",     {63'h0, own},        64'h0);
        check("fetch_inst",      {32'h0, i_rsp_inst}, 64'h1111_2222);
        check("fetch_err",       {63'h0, i_rsp_err},  64'h0);
        step();
        i_req_valid = 0;
        step();

        // Contention: both held, grants alternate starting with D.
        i_req_valid = 1; i_req_addr = 64'h8000_0000;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h8000_0008;
        n = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(20, at, own);
            check("cont_owner",     {63'h0, own}, {63'h0, exp_own[k]});
            check("cont_pulse_cyc", at, n + 3 + 4 * k);
            if (own) check("cont_rdata", d_rsp_rdata, 64'h1111_2222_3333_4444);
            else     check("cont_inst",  {32'h0, i_rsp_inst}, 64'h3333_4444);
        end
        step();
        i_req_valid = 0; d_req_valid = 0;
        step();

        // Backpressure: ready withheld for 5 cycles of valid.
        stall_cfg = 5;
        rd_val = 64'hA5A5_0000_1234_5678;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h8000_0200;
        n = cyc;
        wait_pulse(30, at, own);
        check("bp_pulse_cyc", at, n + 8);
        check("bp_rdata",     d_rsp_rdata, 64'hA5A5_0000_1234_5678);
        step();
        d_req_valid = 0; stall_cfg = 0;
        step();

        // Timeout: no response, error pulse TO cycles after WAIT entry.
        resp_en = 0;
        rd_val = 64'hFFFF_FFFF_FFFF_FFFF;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h8000_0300;
        n = cyc;
        wait_pulse(30, at, own);
        check("to_pulse_cyc", at, n + 2 + TO);
        check("to_err",       {63'h0, d_rsp_err}, 64'h1);
        check("to_rdata",     d_rsp_rdata,        64'h0);
        step();
        d_req_valid = 0;
        stray_at_cyc = cyc + 2;
        count_pulses(8, np);
        check("stray_no_pulse", np, 0);
        step();

        // Reset while waiting for a response: dropped, then a clean fetch.
        i_req_valid = 1; i_req_addr = 64'h8000_0010;
        n = cyc;
        repeat (4) step();
        rst = 1; i_req_valid = 0;
        step();
        rst = 0;
        count_pulses(6, np);
        check("rst_no_pulse", np, 0);
        step();
        resp_en = 1;
        rd_val = 64'hCAFE_F00D_0BAD_BEEF;
        i_req_valid = 1; i_req_addr = 64'h8000_0004;
        n = cyc;
        wait_pulse(20, at, own);
        check("post_rst_pulse_cyc", at, n + 3);
        check("post_rst_inst",      {32'h0, i_rsp_inst}, 64'hCAFE_F00D);
        step();
        i_req_valid = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        n_bad++;
        $display("FAIL global_timeout: bench did not finish by cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "simulation time limit");
    end

endmodule
